// File: rtl/register_file_unit.sv
`default_nettype none
// ============================================================================
// register_file_unit : indexed GP/stack register file with hardware SP
// Optional STACK_GUARD_EN adds SP bounds checks against SB.  Rev 1.0
// ============================================================================
module register_file_unit #(
   parameter int WIDTH       = 16,
   parameter int NREGS       = 16,
   parameter int SELW        = 4,
   parameter int SP_IDX      = 6,
   parameter int SB_IDX      = 7,
   parameter int STACK_DEPTH = 256
) (
   input  logic             clk,
   input  logic             r,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   input  logic [SELW-1:0]  rsi,
   input  logic [SELW-1:0]  rso,
   input  logic [SELW-1:0]  rd_sel_a,
   output logic [WIDTH-1:0] rd_a,
   input  logic [SELW-1:0]  rd_sel_b,
   output logic [WIDTH-1:0] rd_b,
   input  logic             sp_push,
   input  logic             sp_pop,
   output logic [WIDTH-1:0] sp_out,
   output logic [WIDTH-1:0] sb_out,
   output logic             stack_fault,
   input  logic             fault_clr
);

   localparam logic [WIDTH:0] C_DEPTH = (WIDTH+1)'(STACK_DEPTH);

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] w_sp;
   logic [WIDTH-1:0] w_sb;
   logic [WIDTH-1:0] w_sp_next;
   logic             w_sp_wr;
   logic             w_wr_ok;

   // Code 0 is "none"; codes past the last register read as absent.
   function automatic logic sel_ok(input logic [SELW-1:0] sel);
      return (sel != '0) && (int'(sel) < NREGS);
   endfunction

   assign w_sp    = r_regs[SP_IDX];
   assign w_sb    = r_regs[SB_IDX];
   assign w_sp_wr = (rsi == SELW'(SP_IDX));
   assign w_wr_ok = sel_ok(rsi);
   assign sp_out  = w_sp;
   assign sb_out  = w_sb;

`ifdef STACK_GUARD_EN
   logic             w_fault_set;
   logic [WIDTH-1:0] w_depth_used;
   logic             r_fault;

   assign w_depth_used = w_sb - w_sp;
`endif

   always_comb begin
      w_sp_next = w_sp;
`ifdef STACK_GUARD_EN
      w_fault_set = 1'b0;
`endif
      // Simultaneous push and pop cancel; a direct SP write overrides both.
      if (!w_sp_wr && (sp_push != sp_pop)) begin
         if (sp_push) begin
            w_sp_next = w_sp - 1'b1;
`ifdef STACK_GUARD_EN
            if ({1'b0, w_depth_used} >= C_DEPTH) begin
               w_sp_next   = w_sp;
               w_fault_set = 1'b1;
            end
`endif
         end else begin
            w_sp_next = w_sp + 1'b1;
`ifdef STACK_GUARD_EN
            if (w_sp == w_sb) begin
               w_sp_next   = w_sp;
               w_fault_set = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         r_regs[SP_IDX] <= w_sp_next;
         if (w_wr_ok) r_regs[rsi] <= bus_in;
      end
   end

`ifdef STACK_GUARD_EN
   always_ff @(posedge clk or posedge r) begin
      if (r)                r_fault <= 1'b0;
      else if (w_fault_set) r_fault <= 1'b1;
      else if (fault_clr)   r_fault <= 1'b0;
   end

   assign stack_fault = r_fault;
`else
   logic w_unused_guard;

   assign w_unused_guard = fault_clr ^ C_DEPTH[0];
   assign stack_fault    = 1'b0;
`endif

   always_comb begin
      bus_oe  = !r && sel_ok(rso);
      bus_out = '0;
      rd_a    = '0;
      rd_b    = '0;
      if (bus_oe)             bus_out = r_regs[rso];
      if (sel_ok(rd_sel_a))   rd_a    = r_regs[rd_sel_a];
      if (sel_ok(rd_sel_b))   rd_b    = r_regs[rd_sel_b];
   end

endmodule
`default_nettype wire
